// File: rtl/lenet_frame_streamer_if.sv
// Bundles the frame-buffer write port, command/stall inputs and the
// layer-1 stream outputs of lenet_frame_streamer.
//   master : drives wr_en/wr_addr/wr_data/go/hold/layer_done (host or bench)
//   slave  : the streamer; drives busy/start/data_valid_in/pixel_in/
//            frame_done/timeout_err
interface lenet_frame_streamer_if #(
  parameter int MAPSIZE = 32,
  parameter int DATA_W  = 8
);
  localparam int AW = $clog2(MAPSIZE*MAPSIZE);

  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     go;
  logic                     hold;
  logic                     layer_done;
  logic                     busy;
  logic                     start;
  logic                     data_valid_in;
  logic signed [DATA_W-1:0] pixel_in;
  logic                     frame_done;
  logic                     timeout_err;

  modport master (
    output wr_en, wr_addr, wr_data, go, hold, layer_done,
    input  busy, start, data_valid_in, pixel_in, frame_done, timeout_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, go, hold, layer_done,
    output busy, start, data_valid_in, pixel_in, frame_done, timeout_err
  );
endinterface

// File: rtl/lenet_frame_streamer.sv
// Transmit side of the lenet_top layer-1 input. Holds a MAPSIZE x MAPSIZE
// signed frame buffer; on go it pulses start, waits START_GAP cycles,
// streams the frame in raster order (stallable by hold), drains one
// cycle and waits for layer_done, flagging timeout_err after TIMEOUT
// cycles without it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of lenet_frame_streamer_if (write port,
//                go/hold/layer_done in; busy/start/stream/status out)
// All outputs are registered.
module lenet_frame_streamer #(
  parameter int MAPSIZE   = 32,
  parameter int DATA_W    = 8,
  parameter int START_GAP = 2,
  parameter int TIMEOUT   = 3000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lenet_frame_streamer_if.slave bus
);
  localparam int NPIX = MAPSIZE*MAPSIZE;
  localparam int AW   = $clog2(NPIX);
  localparam int TW   = $clog2(TIMEOUT+1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NPIX-1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT-1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
  // Only meaningful when START_GAP > 0 (GAP is skipped otherwise).
  localparam logic [3:0]    GAP_LAST  = 4'(START_GAP-1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_GAP, S_STREAM, S_DRAIN, S_WAIT
  } state_t;

  state_t                   r_state, w_next;
  logic signed [DATA_W-1:0] r_mem [NPIX];
  logic [AW-1:0]            r_addr;
  logic                     r_sent_all;
  logic [3:0]               r_gap;
  logic [TW-1:0]            r_tmo;
  logic                     r_busy, r_start, r_valid, r_frame_done, r_tmo_err;
  logic signed [DATA_W-1:0] r_pixel;
  logic w_gap_done, w_tmo_hit, w_wr_ok;
  logic w_emit, w_go_ok, w_done, w_tmo_fire;

  assign w_gap_done = (r_gap == GAP_LAST);
  assign w_tmo_hit  = (r_tmo == TMO_LAST);

  // Frame buffer: writes only while idle and in range; no reset.
  assign w_wr_ok = bus.wr_en && (r_state == S_IDLE) && (32'(bus.wr_addr) < NPIX);

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[bus.wr_addr] <= bus.wr_data;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.go) w_next = S_START;
      S_START:  w_next = (START_GAP == 0) ? S_STREAM : S_GAP;
      S_GAP:    if (w_gap_done) w_next = S_STREAM;
      S_STREAM: if (r_sent_all) w_next = S_DRAIN;
      S_DRAIN:  w_next = S_WAIT;
      S_WAIT:   if (bus.layer_done || w_tmo_hit) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output decode (registered below). A beat is launched on every edge
  // that lands in STREAM; hold only counts once already streaming, so the
  // first beat after the gap cannot be stalled.
  always_comb begin
    w_emit     = (w_next == S_STREAM) && !((r_state == S_STREAM) && bus.hold);
    w_go_ok    = (r_state == S_IDLE) && bus.go;
    w_done     = (r_state == S_WAIT) && bus.layer_done;
    // layer_done beats a simultaneous terminal count
    w_tmo_fire = (r_state == S_WAIT) && !bus.layer_done && w_tmo_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= 1'b0;
      r_start      <= 1'b0;
      r_valid      <= 1'b0;
      r_pixel      <= '0;
      r_frame_done <= 1'b0;
      r_tmo_err    <= 1'b0;
      r_addr       <= '0;
      r_sent_all   <= 1'b0;
      r_gap        <= '0;
      r_tmo        <= '0;
    end else begin
      r_busy       <= (w_next != S_IDLE);
      r_start      <= (w_next == S_START);
      r_valid      <= w_emit;
      r_pixel      <= w_emit ? r_mem[r_addr] : '0;
      r_frame_done <= w_done;

      if (w_go_ok)         r_tmo_err <= 1'b0;
      else if (w_tmo_fire) r_tmo_err <= 1'b1;

      // Read address parks at the last pixel; r_sent_all ends the frame.
      if (w_go_ok) begin
        r_addr     <= '0;
        r_sent_all <= 1'b0;
      end else if (w_emit) begin
        if (r_addr == ADDR_LAST) r_sent_all <= 1'b1;
        else                     r_addr     <= r_addr + 1'b1;
      end

      if (r_state == S_GAP) r_gap <= r_gap + 1'b1;
      else                  r_gap <= '0;

      // Held at zero outside WAIT_DONE, so it starts from 0 on entry.
      if (r_state != S_WAIT)    r_tmo <= '0;
      else if (r_tmo != TMO_MAX) r_tmo <= r_tmo + 1'b1;
    end
  end

  assign bus.busy          = r_busy;
  assign bus.start         = r_start;
  assign bus.data_valid_in = r_valid;
  assign bus.pixel_in      = r_pixel;
  assign bus.frame_done    = r_frame_done;
  assign bus.timeout_err   = r_tmo_err;
endmodule

// File: tb/tb_lenet_frame_streamer.sv
// Bench for lenet_frame_streamer. The model is the expected image array
// plus frame timing derived from the stream rules; a per-cycle monitor
// checks every beat value and idle-zero pixels, directed sequences check
// latencies, stalls, completion, timeout, ignored commands and reset.
module tb_lenet_frame_streamer;
  localparam int MAPSIZE   = 32;
  localparam int DATA_W    = 8;
  localparam int START_GAP = 2;
  localparam int TIMEOUT   = 3000;
  localparam int NPIX      = MAPSIZE*MAPSIZE;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lenet_frame_streamer_if #(.MAPSIZE(MAPSIZE), .DATA_W(DATA_W)) bus ();

  lenet_frame_streamer #(
    .MAPSIZE(MAPSIZE), .DATA_W(DATA_W), .START_GAP(START_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DATA_W-1:0] img [NPIX];  // expected buffer contents
  int got [NPIX];
  int beat = 0, first_cyc = 0, last_cyc = 0, start_cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Per-cycle monitor
  always @(negedge clk) begin
    if (bus.start) begin
      beat      = 0;
      start_cyc = cyc;
      chk("start_has_busy", int'(bus.busy), 1);
    end
    if (bus.data_valid_in) begin
      if (beat < NPIX) begin
        chk("pixel", int'(bus.pixel_in), int'(img[beat]));
        got[beat] = int'(bus.pixel_in);
      end else begin
        chk("extra_beat", beat, NPIX-1);
      end
      if (beat == 0) first_cyc = cyc;
      last_cyc = cyc;
      beat++;
    end else begin
      chk("pixel_idle_zero", int'(bus.pixel_in), 0);
    end
  end

  task automatic load_image();
    for (int i = 0; i < NPIX; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 10'(i);
      bus.wr_data = 8'(i);
      img[i]      = 8'(i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_go(output int gc);
    chk("busy_before_go", int'(bus.busy), 0);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    gc = cyc;
    chk("start_after_go", int'(bus.start), 1);
    chk("busy_after_go", int'(bus.busy), 1);
  endtask

  // mode 0: plain, 1: hold every 4th STREAM cycle, 2: inject ignored cmds
  task automatic stream_all(input int mode, output int last, output int holds);
    int cnt, guard, ph;
    logic hprev, inj;
    cnt = 0; guard = 0; ph = 0; holds = 0; last = 0;
    while (!bus.data_valid_in && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("first_beat_seen", int'(bus.data_valid_in), 1);
    cnt = 1;
    while (cnt < NPIX && guard < 4000) begin
      ph++;
      bus.hold = (mode == 1) && (ph % 4 == 0);
      hprev    = bus.hold;
      if (hprev) holds++;
      inj = (mode == 2) && (cnt == 100);
      if (inj) begin
        bus.go = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 10'd5;
        bus.wr_data = 8'h7F; bus.layer_done = 1'b1;
      end
      @(negedge clk);
      guard++;
      bus.hold = 1'b0;
      if (inj) begin
        bus.go = 1'b0; bus.wr_en = 1'b0; bus.layer_done = 1'b0;
        chk("ignored_go_no_start", int'(bus.start), 0);
        chk("ignored_done_no_fd", int'(bus.frame_done), 0);
        chk("ignored_busy", int'(bus.busy), 1);
      end
      chk("beat_vs_hold", int'(bus.data_valid_in), int'(!hprev));
      if (bus.data_valid_in) cnt++;
    end
    chk("stream_beats_reached", cnt, NPIX);
    last = cyc;
    @(negedge clk);
    chk("valid_low_after", int'(bus.data_valid_in), 0);
    chk("monitor_beats", beat, NPIX);
    chk("span", last_cyc - first_cyc + 1, NPIX + holds);
  endtask

  task automatic complete(input int last, input int delay);
    while (cyc < last + delay) @(negedge clk);
    bus.layer_done = 1'b1;
    @(negedge clk);
    bus.layer_done = 1'b0;
    chk("frame_done_pulse", int'(bus.frame_done), 1);
    chk("busy_low_at_done", int'(bus.busy), 0);
    chk("no_tmo_at_done", int'(bus.timeout_err), 0);
    @(negedge clk);
    chk("frame_done_one_cycle", int'(bus.frame_done), 0);
  endtask

  initial begin
    int gc, last, holds, cnt, guard;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.go = 0; bus.hold = 0; bus.layer_done = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.data_valid_in), 0);
    chk("rst_tmo", int'(bus.timeout_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_start", int'(bus.start), 0);

    load_image();

    // Basic frame + completion 50 cycles after last beat
    pulse_go(gc);
    @(negedge clk);
    chk("start_one_cycle", int'(bus.start), 0);
    stream_all(0, last, holds);
    chk("first_beat_latency", first_cyc - (start_cyc + 1), 2);
    chk("beat0", got[0], 0);
    chk("beat127", got[127], 127);
    chk("beat128", got[128], -128);
    chk("beat1023", got[1023], -1);
    complete(last, 50);

    // Backpressure
    pulse_go(gc);
    stream_all(1, last, holds);
    chk("holds_applied", int'(holds > 200), 1);
    complete(last, 5);

    // Timeout: WAIT_DONE is entered 2 edges after the last beat edge
    pulse_go(gc);
    stream_all(0, last, holds);
    while (cyc < last + 2 + TIMEOUT - 1) @(negedge clk);
    chk("tmo_not_yet", int'(bus.timeout_err), 0);
    chk("busy_before_tmo", int'(bus.busy), 1);
    @(negedge clk);
    chk("tmo_set", int'(bus.timeout_err), 1);
    chk("busy_after_tmo", int'(bus.busy), 0);
    chk("no_fd_on_tmo", int'(bus.frame_done), 0);
    repeat (5) @(negedge clk);
    chk("tmo_sticky", int'(bus.timeout_err), 1);

    // Ignored commands, then layer_done on the terminal-count cycle
    pulse_go(gc);
    chk("tmo_cleared_by_go", int'(bus.timeout_err), 0);
    stream_all(2, last, holds);
    chk("pix5_kept", got[5], 5);
    while (cyc < last + 2 + TIMEOUT - 1) @(negedge clk);
    bus.layer_done = 1'b1;
    @(negedge clk);
    bus.layer_done = 1'b0;
    chk("tie_frame_done", int'(bus.frame_done), 1);
    chk("tie_tmo", int'(bus.timeout_err), 0);
    chk("tie_busy", int'(bus.busy), 0);
    @(negedge clk);

    // Reset mid-stream at beat 500
    pulse_go(gc);
    cnt = 0; guard = 0;
    while (cnt < 500 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (bus.data_valid_in) cnt++;
    end
    chk("reached_beat500", cnt, 500);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_start", int'(bus.start), 0);
    chk("arst_valid", int'(bus.data_valid_in), 0);
    chk("arst_pixel", int'(bus.pixel_in), 0);
    chk("arst_fd", int'(bus.frame_done), 0);
    chk("arst_tmo", int'(bus.timeout_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_restart_wo_go", int'(bus.busy), 0);
    pulse_go(gc);
    stream_all(0, last, holds);
    chk("post_rst_beat0", got[0], 0);
    chk("post_rst_beat5", got[5], 5);
    chk("post_rst_beat1023", got[1023], -1);
    complete(last, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
